// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic array front end.
//   - DEF_DATA_SIZE  : default element width (matches the PE data_size)
//   - feeder_state_e : feeder FSM encoding (IDLE=0, CLEAR=1, FEED=2,
//                      FLUSH=3, DONE=4)
//   - lane_slice()   : LSB index of lane i inside a packed lane vector
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEF_DATA_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

    // Lane i occupies bits [lane_slice(i, w) +: w] of a packed vector.
    function automatic int lane_slice(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// -----------------------------------------------------------------------------
// skew_delay_line
//   Per-lane shift register used to build the diagonal skew. It holds
//   DEPTH+1 stages; stage 0 loads din_i and stage j loads stage j-1, all only
//   when adv_i is high. DEPTH=0 degenerates to a single output register.
//   Each stage carries a tag saying whether it holds a real beat (1) or an
//   injected flush zero (0); the tag of the last stage becomes the row enable.
//
// Parameters
//   DATA_SIZE  element width
//   DEPTH      extra delay in advances (lane index)
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   adv_i   in   shift enable (one array advance)
//   din_i   in   DATA_SIZE  value entering stage 0
//   vld_i   in   tag entering stage 0 (1 = real beat)
//   dout_o  out  DATA_SIZE  last stage, drives the PE row in_a
//   vld_o   out  row input_en: high for one cycle after an advance that
//                delivered a real beat to the last stage
// -----------------------------------------------------------------------------
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int DEPTH     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv_i,
    input  logic [DATA_SIZE-1:0] din_i,
    input  logic                 vld_i,
    output logic [DATA_SIZE-1:0] dout_o,
    output logic                 vld_o
);

    logic [DEPTH:0][DATA_SIZE-1:0] data_q, data_d;
    logic [DEPTH:0]                tag_q, tag_d;
    logic                          en_q, en_d;

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (adv_i) begin
            data_d[0] = din_i;
            tag_d[0]  = vld_i;
            for (int j = 1; j <= DEPTH; j++) begin
                data_d[j] = data_q[j-1];
                tag_d[j]  = tag_q[j-1];
            end
        end
        // The enable is a pulse: it only follows an advance, never a stall.
        en_d = adv_i & tag_d[DEPTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            tag_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            en_q   <= en_d;
        end
    end

    assign dout_o = data_q[DEPTH];
    assign vld_o  = en_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//   West-edge (A) feeder for the systolic PE array. Accepts one LANES-wide
//   row vector per beat over valid/ready, skews it diagonally (lane i is
//   delayed i advances), clears the PE accumulators before a tile and flushes
//   the array with LANES-1 zero advances after the last beat.
//
// Build option
//   SKEW_SKID_EN  when defined, a 2-entry skid buffer sits on the input and
//                 vec_ready is a register; otherwise vec_ready is decoded
//                 from the state and beats go straight into the delay lines.
//
// Parameters
//   DATA_SIZE  element width
//   LANES      number of PE rows fed
//   MAX_K      maximum beats per tile (k_cnt saturates here)
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   vec_valid  in   upstream vector valid
//   vec_ready  out  feeder accepts a beat this cycle
//   vec_data   in   LANES*DATA_SIZE, lane i = [i*DATA_SIZE +: DATA_SIZE]
//   vec_last   in   final beat of the tile
//   lane_data  out  LANES*DATA_SIZE skewed data to the PE rows' in_a
//   feed_en    out  LANES per-row input_en
//   acc_clr    out  one-cycle PE accumulator clear
//   tile_done  out  one-cycle pulse after the flush completes
//   k_cnt      out  beats accepted in the current/last tile
// -----------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int LANES     = 4,
    parameter int MAX_K     = 256,
    localparam int KW       = $clog2(MAX_K + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [LANES*DATA_SIZE-1:0] vec_data,
    input  logic                       vec_last,
    output logic [LANES*DATA_SIZE-1:0] lane_data,
    output logic [LANES-1:0]           feed_en,
    output logic                       acc_clr,
    output logic                       tile_done,
    output logic [KW-1:0]              k_cnt
);

    localparam int FW         = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FLUSH_LAST = (LANES > 1) ? LANES - 2 : 0;

    feeder_state_e state_q, state_d;
    logic [KW-1:0] k_cnt_q, k_cnt_d;
    logic [FW-1:0] flush_q, flush_d;

    logic                       accept;     // upstream handshake this cycle
    logic                       beat_vld;   // a beat is available to advance
    logic [LANES*DATA_SIZE-1:0] beat_data;
    logic                       beat_last;
    logic                       adv;        // delay lines shift this cycle
    logic                       inj_zero;   // this advance injects flush zeros
    logic [LANES*DATA_SIZE-1:0] feed_vec;

`ifdef SKEW_SKID_EN
    // Two-entry skid buffer; each entry carries its vec_last flag.
    logic [LANES*DATA_SIZE-1:0] buf_data_q [2];
    logic [1:0]                 buf_last_q;
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0]                 buf_cnt_q, buf_cnt_d;
    logic                       last_in_q, last_in_d;  // last beat already taken
    logic                       ready_q, ready_d;
    logic                       pop;

    assign accept    = vec_valid & ready_q;
    assign vec_ready = ready_q;
    assign beat_vld  = (buf_cnt_q != 2'd0);
    assign beat_data = buf_data_q[rd_ptr_q];
    assign beat_last = buf_last_q[rd_ptr_q];
    assign pop       = adv & (state_q == ST_FEED);

    always_comb begin
        buf_cnt_d = buf_cnt_q;
        case ({accept, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase

        last_in_d = last_in_q;
        if (state_q == ST_IDLE && state_d == ST_CLEAR) begin
            last_in_d = 1'b0;
        end else if (accept && vec_last) begin
            last_in_d = 1'b1;
        end

        // Registered ready: look at where the FSM and buffer will be next
        // cycle, and stop taking beats once the tile's last beat is in.
        ready_d = ((state_d == ST_CLEAR) || (state_d == ST_FEED)) &&
                  (buf_cnt_d != 2'd2) && !last_in_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            buf_cnt_q     <= 2'd0;
            last_in_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            if (accept) begin
                buf_data_q[wr_ptr_q] <= vec_data;
                buf_last_q[wr_ptr_q] <= vec_last;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_d;
            last_in_q <= last_in_d;
            ready_q   <= ready_d;
        end
    end
`else
    // No buffering: ready is decoded from the state, beats go straight in.
    assign vec_ready = (state_q == ST_FEED);
    assign accept    = vec_valid & vec_ready;
    assign beat_vld  = vec_valid;
    assign beat_data = vec_data;
    assign beat_last = vec_last;
`endif

    // Next-state, advance control and beat counter.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        k_cnt_d  = k_cnt_q;
        adv      = 1'b0;
        inj_zero = 1'b0;

        if (accept && (k_cnt_q < KW'(MAX_K))) begin
            k_cnt_d = k_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // vec_valid only wakes the feeder; the beat is taken in FEED.
                if (vec_valid) begin
                    state_d = ST_CLEAR;
                    k_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (beat_vld) begin
                    adv = 1'b1;
                    if (beat_last) begin
                        flush_d = '0;
                        state_d = (LANES > 1) ? ST_FLUSH : ST_DONE;
                    end
                end
            end
            ST_FLUSH: begin
                adv      = 1'b1;
                inj_zero = 1'b1;
                if (flush_q == FLUSH_LAST[FW-1:0]) begin
                    state_d = ST_DONE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_cnt_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            k_cnt_q <= k_cnt_d;
            flush_q <= flush_d;
        end
    end

    assign acc_clr   = (state_q == ST_CLEAR);
    assign tile_done = (state_q == ST_DONE);
    assign k_cnt     = k_cnt_q;

    assign feed_vec  = inj_zero ? '0 : beat_data;

    // Lane i passes through i+1 registers, giving the diagonal skew.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_delay_line #(
            .DATA_SIZE (DATA_SIZE),
            .DEPTH     (i)
        ) u_delay (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .din_i  (feed_vec[lane_slice(i, DATA_SIZE) +: DATA_SIZE]),
            .vld_i  (~inj_zero),
            .dout_o (lane_data[lane_slice(i, DATA_SIZE) +: DATA_SIZE]),
            .vld_o  (feed_en[i])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//   Drives tiles into two feeders (A edge and B edge of a 4x4 array) and
//   compares every cycle against an index-arithmetic model: at the a-th
//   advance of a tile, row i must carry element i of beat a-i with
//   feed_en[i]=1 when 0 <= a-i < K, and zero with feed_en[i]=0 otherwise;
//   between advances the rows must hold their values.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

    localparam int L  = 4;
    localparam int DS = 8;
    localparam int MK = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          vec_valid, vec_last;
    logic [31:0]   vec_data, vec_data_b;
    logic          vec_ready, vec_ready_b;
    logic [31:0]   lane_data, lane_data_b;
    logic [3:0]    feed_en, feed_en_b;
    logic          acc_clr, acc_clr_b, tile_done, tile_done_b;
    logic [2:0]    k_cnt, k_cnt_b;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DATA_SIZE(DS), .LANES(L), .MAX_K(MK)) dut (
        .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_data(vec_data), .vec_last(vec_last), .lane_data(lane_data),
        .feed_en(feed_en), .acc_clr(acc_clr), .tile_done(tile_done), .k_cnt(k_cnt)
    );

    systolic_skew_feeder #(.DATA_SIZE(DS), .LANES(L), .MAX_K(MK)) dut_b (
        .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready_b),
        .vec_data(vec_data_b), .vec_last(vec_last), .lane_data(lane_data_b),
        .feed_en(feed_en_b), .acc_clr(acc_clr_b), .tile_done(tile_done_b), .k_cnt(k_cnt_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tb_beats   [16];
    logic [31:0] tb_beats_b [16];
    int          tb_k;
    logic [31:0] held_lane;

    typedef struct {
        int               k;
        int               gap;
        int               exp_k;
        int               exp_flush;
        logic [7:0][31:0] beats;
    } tile_vec_t;

    tile_vec_t tbl [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural output-stationary PE array ----------------
    int         acc_m [L][L];
    logic [7:0] pa [L][L];
    logic [7:0] pb [L][L];
    logic       pae [L][L];
    logic       pbe [L][L];
    logic [7:0] m_ain, m_bin;
    logic       m_aen, m_ben;

    always @(negedge clk) begin
        for (int r = L-1; r >= 0; r--) begin
            for (int c = L-1; c >= 0; c--) begin
                if (!rst) begin
                    acc_m[r][c] = 0; pa[r][c] = '0; pb[r][c] = '0;
                    pae[r][c] = 1'b0; pbe[r][c] = 1'b0;
                end else begin
                    m_ain = (c == 0) ? lane_data[r*8 +: 8]   : pa[r][c-1];
                    m_aen = (c == 0) ? feed_en[r]            : pae[r][c-1];
                    m_bin = (r == 0) ? lane_data_b[c*8 +: 8] : pb[r-1][c];
                    m_ben = (r == 0) ? feed_en_b[c]          : pbe[r-1][c];
                    if (acc_clr) acc_m[r][c] = 0;
                    else if (m_aen && m_ben) acc_m[r][c] = acc_m[r][c] + int'(m_ain) * int'(m_bin);
                    pa[r][c] = m_ain; pae[r][c] = m_aen;
                    pb[r][c] = m_bin; pbe[r][c] = m_ben;
                end
            end
        end
    end

    // ---------------- one tile: drive, observe, compare ----------------
    task automatic run_tile(input int gap, input bit rnd, input int abort_adv,
                            input int exp_k, input int exp_flush);
        int sent, adv, clr_n, clr_cyc, first_fe, first_acc, last0_cyc, done_n, done_cyc, gap_left, idx;
        bit acc_pend;
        logic [31:0] exp_lane;
        logic [3:0]  exp_fe;
        sent = 0; adv = 0; clr_n = 0; clr_cyc = -100; first_fe = -1; first_acc = -1;
        last0_cyc = -100; done_n = 0; done_cyc = -1; gap_left = gap; acc_pend = 1'b0;
        vec_valid  = 1'b1;
        vec_data   = tb_beats[0];
        vec_data_b = tb_beats_b[0];
        vec_last   = (tb_k == 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (acc_pend) sent++;
            if (acc_clr) begin clr_n++; clr_cyc = cyc; end
            if (feed_en != 4'd0) begin
                exp_lane = '0; exp_fe = '0;
                for (int i = 0; i < L; i++) begin
                    idx = adv - i;
                    if (idx >= 0 && idx < tb_k) begin
                        exp_fe[i] = 1'b1;
                        exp_lane[i*8 +: 8] = tb_beats[idx][i*8 +: 8];
                    end
                end
                check("feed_en", 64'(feed_en), 64'(exp_fe));
                check("lane_data", 64'(lane_data), 64'(exp_lane));
                held_lane = exp_lane;
                if (adv == 0) first_fe = cyc;
                if (adv == tb_k - 1) last0_cyc = cyc;
                adv++;
            end else begin
                check("lane_hold", 64'(lane_data), 64'(held_lane));
            end
            if (tile_done) begin
                done_n++; done_cyc = cyc;
                check("k_cnt_done", 64'(k_cnt), 64'(exp_k));
            end
            if (abort_adv >= 0 && adv == abort_adv) begin
                #2 rst = 1'b0;
                #1;
                check("rst_lane", 64'(lane_data), 64'd0);
                check("rst_fe", 64'(feed_en), 64'd0);
                check("rst_kcnt", 64'(k_cnt), 64'd0);
                check("rst_ready", 64'(vec_ready), 64'd0);
                check("rst_done", 64'(tile_done), 64'd0);
                check("rst_clr", 64'(acc_clr), 64'd0);
                vec_valid = 1'b0;
                repeat (3) begin @(negedge clk); check("rst_no_done", 64'(tile_done), 64'd0); end
                rst = 1'b1;
                held_lane = '0;
                repeat (4) begin
                    @(negedge clk);
                    check("post_rst_done", 64'(tile_done), 64'd0);
                    check("post_rst_fe", 64'(feed_en), 64'd0);
                end
                return;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                check("k_cnt_hold", 64'(k_cnt), 64'(exp_k));
                break;
            end
            if (sent >= tb_k) begin
                // valid stays high through DONE; it must not be taken
                vec_valid  = (done_cyc < 0 || cyc == done_cyc);
                vec_data   = $urandom;
                vec_data_b = $urandom;
                vec_last   = 1'($urandom);
            end else begin
                if (sent == 1 && gap_left > 0) begin
                    vec_valid = 1'b0; gap_left--;
                end else begin
                    vec_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                vec_data   = vec_valid ? tb_beats[sent] : $urandom;
                vec_data_b = tb_beats_b[sent];
                vec_last   = vec_valid ? (sent == tb_k - 1) : 1'($urandom);
            end
            acc_pend = vec_valid & vec_ready;
            if (acc_pend && first_acc < 0) first_acc = cyc;
        end
        vec_valid = 1'b0;
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        check("done_once", 64'(done_n), 64'd1);
        check("clr_once", 64'(clr_n), 64'd1);
        check("adv_total", 64'(adv), 64'(tb_k + L - 1));
        check("flush_len", 64'(done_cyc - last0_cyc), 64'(exp_flush));
        if (!rnd) begin
            check("clr_to_feed_en", 64'(first_fe - clr_cyc), 64'd2);
`ifndef SKEW_SKID_EN
            check("clr_to_accept", 64'(first_acc - clr_cyc), 64'd1);
`endif
        end
    endtask

    task automatic load_tbl(input int t);
        tb_k = tbl[t].k;
        for (int j = 0; j < 8; j++) tb_beats[j] = tbl[t].beats[j];
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; vec_valid = 1'b0; vec_last = 1'b0; vec_data = '0; vec_data_b = '0;
        held_lane = '0;
        for (int j = 0; j < 16; j++) begin tb_beats[j] = '0; tb_beats_b[j] = '0; end

        tbl[0].k = 3; tbl[0].gap = 0; tbl[0].exp_k = 3; tbl[0].exp_flush = 3; tbl[0].beats = '0;
        tbl[0].beats[0] = 32'h04030201; tbl[0].beats[1] = 32'h08070605; tbl[0].beats[2] = 32'h0C0B0A09;
        tbl[1] = tbl[0]; tbl[1].gap = 2;
        tbl[2].k = 1; tbl[2].gap = 0; tbl[2].exp_k = 1; tbl[2].exp_flush = 3; tbl[2].beats = '0;
        tbl[2].beats[0] = 32'h07070707;
        tbl[3].k = 8; tbl[3].gap = 0; tbl[3].exp_k = MK; tbl[3].exp_flush = 3; tbl[3].beats = '0;
        for (int j = 0; j < 8; j++) tbl[3].beats[j] = 32'h11111111 * (j + 1);

        // reset state
        repeat (2) @(negedge clk);
        check("reset_lane", 64'(lane_data), 64'd0);
        check("reset_fe", 64'(feed_en), 64'd0);
        check("reset_ready", 64'(vec_ready), 64'd0);
        check("reset_clr", 64'(acc_clr), 64'd0);
        check("reset_done", 64'(tile_done), 64'd0);
        check("reset_kcnt", 64'(k_cnt), 64'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 64'(vec_ready), 64'd0);
            check("idle_clr", 64'(acc_clr), 64'd0);
        end

        // directed tiles from the table
        for (int t = 0; t < 4; t++) begin
            load_tbl(t);
            run_tile(tbl[t].gap, 1'b0, -1, tbl[t].exp_k, tbl[t].exp_flush);
        end

        // reset during FLUSH, then a normal tile
        load_tbl(0);
        run_tile(0, 1'b0, tb_k + 1, 0, L - 1);
        load_tbl(0);
        run_tile(0, 1'b0, -1, 3, L - 1);

        // end-to-end: A = identity, B = [1..16]
        tb_k = 4;
        for (int k = 0; k < 4; k++) begin
            tb_beats[k] = 32'h1 << (8 * k);
            for (int j = 0; j < 4; j++) tb_beats_b[k][j*8 +: 8] = 8'(4 * k + j + 1);
        end
        run_tile(0, 1'b0, -1, 4, L - 1);
        repeat (8) @(negedge clk);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                check("pe_out_c", 64'(acc_m[r][c]), 64'(4 * r + c + 1));

        // random tiles with random vec_valid
        for (int t = 0; t < 10; t++) begin
            tb_k = $urandom_range(1, 9);
            for (int j = 0; j < 16; j++) begin tb_beats[j] = $urandom; tb_beats_b[j] = $urandom; end
            run_tile(0, 1'b1, -1, (tb_k > MK) ? MK : tb_k, L - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
